// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//   Memory-mapped 8N1 UART transmitter hanging off the CPU store bus.
//   Bytes stored to TXDATA are queued in a small FIFO.
//   A bit-serial FSM drains the FIFO onto tx, sending back-to-back frames
//   with no idle gap while the FIFO still holds data.
//
// Register window (16 bytes at BASE_ADDR, offset = Mem_WrAddr[3:2]):
//   0x0 TXDATA  write: push Mem_WrData[7:0]; read: 0
//   0x4 STATUS  read : [0] busy, [1] full, [2] empty, [3] overflow (sticky),
//                      [15:8] FIFO count
//               write: Mem_WrData[3]=1 clears overflow
//   0x8, 0xC    read 0, writes ignored
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high
//   MemWrite    store strobe from the CPU
//   Mem_WrAddr  load/store byte address
//   Mem_WrData  store data
//   io_sel      combinational window decode
//   io_rdata    combinational read data (0 when io_sel=0)
//   tx          registered serial output, idles high
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_2000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic        io_sel,
  output logic [31:0] io_rdata,
  output logic        tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic [7:0]    fifo_mem [FIFO_DEPTH];

  logic [1:0]    offset;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          ovf_clr;
  logic          bit_last;
  logic          busy;
  logic [7:0]    count8;
  logic [7:0]    fifo_head;

  // Address bits below the word and data bits above the byte have no meaning here.
  logic unused_bits;
  assign unused_bits = ^{Mem_WrData[31:8], Mem_WrAddr[1:0]};

  // ---------------------------------------------------------------- decode
  assign offset     = Mem_WrAddr[3:2];
  assign io_sel     = (Mem_WrAddr[31:4] == BASE_ADDR[31:4]);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push_req   = MemWrite && io_sel && (offset == 2'd0);
  // A push into a full FIFO is dropped even if the FSM pops on the same edge.
  assign push       = push_req && !fifo_full;
  assign ovf_clr    = MemWrite && io_sel && (offset == 2'd1) && Mem_WrData[3];
  assign busy       = (state_q != S_IDLE);
  assign count8     = 8'(count_q);
  assign fifo_head  = fifo_mem[rd_ptr_q];
  assign tx         = tx_q;

  // ------------------------------------------------------------ read mux
  always_comb begin
    io_rdata = 32'h0;
    if (io_sel && (offset == 2'd1)) begin
      io_rdata = {16'h0, count8, 4'h0, ovf_q, fifo_empty, fifo_full, busy};
    end
  end

  // ---------------------------------------------------------- transmit FSM
  assign bit_last = (bit_cnt_q == BIT_LAST);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        bit_idx_d = 3'd0;
        tx_d      = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (bit_last) begin
          bit_cnt_d = '0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
          tx_d      = shift_q[0];
        end
      end
      S_DATA: begin
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (bit_last) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            // Shift register always presents the current bit at [0].
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end
      S_STOP: begin
        bit_cnt_d = bit_cnt_q + BW'(1);
        tx_d      = 1'b1;
        if (bit_last) begin
          bit_cnt_d = '0;
          if (!fifo_empty) begin
            // Chain straight into the next frame with no idle gap.
            pop     = 1'b1;
            shift_d = fifo_head;
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // ------------------------------------------------------ FIFO bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Setting beats clearing when both happen on one edge.
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (push_req && fifo_full) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= Mem_WrData[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule
